// File: rtl/tick_counter_pkg.sv
// Shared types and elaboration helpers for the tick-driven counter family.
// calc_div returns 0 for an unusable clock/tick ratio so callers can reject it.
package tick_counter_pkg;

    typedef enum logic {
        OVF_WRAP = 1'b0,
        OVF_SAT  = 1'b1
    } ovf_mode_t;

    function automatic int calc_div(input int clk_freq, input int tick_hz);
        int div;
        div = 0;
        if (tick_hz > 0) begin
            if ((clk_freq % tick_hz) == 0) begin
                div = clk_freq / tick_hz;
            end
        end
        return div;
    endfunction

endpackage

// File: rtl/tick_counter_if.sv
// Control and status bundle between a tick_counter and its owner.
// master drives the controls and observes the count; slave is the counter side.
interface tick_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clear;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             wrap;

    modport master (
        output en, up, load, load_val, clear,
        input  count, tick, wrap
    );

    modport slave (
        input  en, up, load, load_val, clear,
        output count, tick, wrap
    );
endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler emitting a registered one-cycle tick every DIV cycles.
// Latency: first tick DIV cycles after reset release, then exactly every DIV cycles.
// Backpressure: none; the prescaler never stalls.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;

    always_comb begin
        presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
        tick_d  = (presc_q == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/tick_counter.sv
// Tick-stepped up/down counter with modulus, load/clear and wrap-or-saturate limits.
// Latency: tick/load/clear on cycle N -> new count and wrap visible on cycle N+1.
// Backpressure: none; controls are sampled every cycle, steps only on tick cycles.
module tick_counter
    import tick_counter_pkg::*;
#(
    parameter int        CLK_FREQ = 12_000_000,
    parameter int        TICK_HZ  = 1,
    parameter int        WIDTH    = 8,
    parameter int        MOD      = 256,
    parameter ovf_mode_t OVF_MODE = OVF_WRAP
) (
    input  logic         clk,
    input  logic         rst_n,
    tick_counter_if.slave bus
);
    localparam int DIV = calc_div(CLK_FREQ, TICK_HZ);

    if (DIV < 2) begin : g_bad_div
        $error("tick_counter: CLK_FREQ/TICK_HZ must divide exactly and be >= 2");
    end
    if (MOD < 2 || longint'(MOD) > (longint'(1) << WIDTH)) begin : g_bad_mod
        $error("tick_counter: MOD must lie in 2..2**WIDTH");
    end

    // One extra bit so MOD-1 and clamp compares stay exact when MOD == 2**WIDTH.
    localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(MOD - 1);

    logic             tick;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.clear) begin
            count_d = '0;
        end else if (bus.load) begin
            count_d = ({1'b0, bus.load_val} > LAST) ? LAST[WIDTH-1:0] : bus.load_val;
        end else if (tick && bus.en) begin
            if (bus.up) begin
                if ({1'b0, count_q} == LAST) begin
                    wrap_d = 1'b1;
                    if (OVF_MODE == OVF_WRAP) count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    wrap_d = 1'b1;
                    if (OVF_MODE == OVF_WRAP) count_d = LAST[WIDTH-1:0];
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tick  = tick;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_tick_counter.sv
// Drives three counter variants (WRAP mod 10, SAT mod 10, WRAP mod 16) from one
// stimulus stream and compares every cycle against an arithmetic reference model.
module tb_tick_counter;
    import tick_counter_pkg::*;

    localparam int DIV = 5;
    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, up = 1'b0, load = 1'b0, clear = 1'b0;
    logic [3:0] load_val = '0;

    always #5 clk = ~clk;

    tick_counter_if #(.WIDTH(4)) bus_w ();
    tick_counter_if #(.WIDTH(4)) bus_s ();
    tick_counter_if #(.WIDTH(4)) bus_m ();

    assign bus_w.en = en;  assign bus_w.up = up;  assign bus_w.load = load;
    assign bus_w.load_val = load_val;  assign bus_w.clear = clear;
    assign bus_s.en = en;  assign bus_s.up = up;  assign bus_s.load = load;
    assign bus_s.load_val = load_val;  assign bus_s.clear = clear;
    assign bus_m.en = en;  assign bus_m.up = up;  assign bus_m.load = load;
    assign bus_m.load_val = load_val;  assign bus_m.clear = clear;

    tick_counter #(.CLK_FREQ(10), .TICK_HZ(2), .WIDTH(4), .MOD(10), .OVF_MODE(OVF_WRAP))
        dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w.slave));
    tick_counter #(.CLK_FREQ(10), .TICK_HZ(2), .WIDTH(4), .MOD(10), .OVF_MODE(OVF_SAT))
        dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s.slave));
    tick_counter #(.CLK_FREQ(10), .TICK_HZ(2), .WIDTH(4), .MOD(16), .OVF_MODE(OVF_WRAP))
        dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edges since reset, and per-variant count/wrap.
    int m_edges;
    int m_cnt [NDUT];
    bit m_wrap[NDUT];
    int mods  [NDUT] = '{10, 10, 16};
    bit sat   [NDUT] = '{1'b0, 1'b1, 1'b0};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit m_tick(input int e);
        return (e > 0) && (e % DIV == 0);
    endfunction

    task automatic model_reset();
        m_edges = 0;
        for (int i = 0; i < NDUT; i++) begin
            m_cnt[i]  = 0;
            m_wrap[i] = 1'b0;
        end
    endtask

    task automatic cmp_all();
        check_val("tick",    {31'd0, bus_w.tick}, {31'd0, m_tick(m_edges)});
        check_val("w.count", {28'd0, bus_w.count}, m_cnt[0]);
        check_val("w.wrap",  {31'd0, bus_w.wrap},  {31'd0, m_wrap[0]});
        check_val("s.count", {28'd0, bus_s.count}, m_cnt[1]);
        check_val("s.wrap",  {31'd0, bus_s.wrap},  {31'd0, m_wrap[1]});
        check_val("m.count", {28'd0, bus_m.count}, m_cnt[2]);
        check_val("m.wrap",  {31'd0, bus_m.wrap},  {31'd0, m_wrap[2]});
        check_val("s.tick",  {31'd0, bus_s.tick}, {31'd0, m_tick(m_edges)});
        check_val("m.tick",  {31'd0, bus_m.tick}, {31'd0, m_tick(m_edges)});
    endtask

    // Advance one clock: compute the model's next state from the current
    // inputs, then compare shortly after the edge.
    task automatic cycle();
        bit tk;
        int nc [NDUT];
        bit nw [NDUT];
        tk = m_tick(m_edges);
        for (int i = 0; i < NDUT; i++) begin
            nc[i] = m_cnt[i];
            nw[i] = 1'b0;
            if (clear) begin
                nc[i] = 0;
            end else if (load) begin
                nc[i] = (int'(load_val) >= mods[i]) ? mods[i] - 1 : int'(load_val);
            end else if (tk && en) begin
                if (up) begin
                    if (m_cnt[i] + 1 >= mods[i]) begin
                        nw[i] = 1'b1;
                        nc[i] = sat[i] ? m_cnt[i] : 0;
                    end else begin
                        nc[i] = m_cnt[i] + 1;
                    end
                end else begin
                    if (m_cnt[i] - 1 < 0) begin
                        nw[i] = 1'b1;
                        nc[i] = sat[i] ? m_cnt[i] : mods[i] - 1;
                    end else begin
                        nc[i] = m_cnt[i] - 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        m_edges++;
        for (int i = 0; i < NDUT; i++) begin
            m_cnt[i]  = nc[i];
            m_wrap[i] = nw[i];
        end
        cmp_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        bit found;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        cmp_all();

        // Count up through the wrap at 9 (15 for mod 16).
        en = 1'b1; up = 1'b1;
        run(5);
        check_val("first_tick", {31'd0, bus_w.tick}, 32'd1);
        run(85);

        // Count down, wrapping below zero.
        up = 1'b0;
        run(30);

        // Load 8 then step up into the upper limit.
        load = 1'b1; load_val = 4'd8; cycle(); load = 1'b0;
        up = 1'b1;
        run(25);
        up = 1'b0;
        run(10);

        // Out-of-range load clamps to MOD-1.
        load = 1'b1; load_val = 4'd13; cycle(); load = 1'b0;
        check_val("load_clamp", {28'd0, bus_w.count}, 32'd9);

        // Load on a tick cycle swallows that step.
        found = 1'b0;
        for (int k = 0; k < 2 * DIV && !found; k++) begin
            if (m_tick(m_edges)) found = 1'b1;
            else cycle();
        end
        if (!found) check_val("tick_wait", 32'd0, 32'd1);
        up = 1'b1; load = 1'b1; load_val = 4'd3; cycle(); load = 1'b0;
        check_val("load_on_tick", {28'd0, bus_w.count}, 32'd3);
        run(12);

        // Clear beats load.
        clear = 1'b1; load = 1'b1; load_val = 4'd5; cycle();
        clear = 1'b0; load = 1'b0;
        check_val("clr_over_ld", {28'd0, bus_w.count}, 32'd0);
        run(3);

        // Disabled across three ticks.
        en = 1'b0;
        run(16);
        en = 1'b1;

        // Full-range counter wraps 15 -> 0.
        load = 1'b1; load_val = 4'd15; cycle(); load = 1'b0;
        run(2 * DIV + 2);

        // Asynchronous reset mid-period.
        run(2);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst.count", {28'd0, bus_w.count}, 32'd0);
        check_val("arst.tick",  {31'd0, bus_w.tick},  32'd0);
        check_val("arst.wrap",  {31'd0, bus_m.wrap},  32'd0);
        #3 rst_n = 1'b1;
        model_reset();
        run(12);

        // Randomized control mix.
        for (int k = 0; k < 800; k++) begin
            if (k % 7 == 0) up = 1'($urandom_range(1));
            en       = ($urandom_range(3) != 0);
            load     = ($urandom_range(19) == 0);
            clear    = ($urandom_range(29) == 0);
            load_val = 4'($urandom_range(15));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tick_counter.md
# tick_counter

Parametrised, tick-driven up/down counter that produces a value for the hex display driver (`dev_hex`) or any other consumer. An internal prescaler divides the system clock to an exact tick rate, and the counter steps once per tick. Counting supports a configurable modulus, direction, synchronous load/clear and a choice of wrap or saturate at the limits. It sits between the board clock and display/LED drivers in the top-level designs.

## Interface
- `CLK_FREQ`, 12_000_000, input clock frequency in Hz
- `TICK_HZ`, 1, step rate in Hz; `DIV = CLK_FREQ / TICK_HZ`, elaboration error if `DIV < 2` or the division has a remainder
- `WIDTH`, 8, counter width in bits
- `MOD`, 256, count range `0..MOD-1`; elaboration error if `MOD < 2` or `MOD > 2**WIDTH`
- `OVF_MODE`, `OVF_WRAP`, `ovf_mode_t` from `tick_counter_pkg`; either `OVF_WRAP` or `OVF_SAT`
- `clk` in 1: system clock, all logic on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `en` in 1: count enable, sampled on tick cycles only
- `up` in 1: direction, 1 = increment, 0 = decrement
- `load` in 1: synchronous load of `load_val`
- `load_val` in WIDTH: load value; values ≥ MOD are clamped to MOD-1
- `clear` in 1: synchronous clear to 0
- `count` out WIDTH: current count
- `tick` out 1: one-cycle prescaler pulse
- `wrap` out 1: one-cycle pulse when count wrapped (WRAP mode) or was held at a limit (SAT mode)

## Operation
- Reset values: `count`=0, `tick`=0, `wrap`=0, prescaler=0.
- Prescaler counts `0..DIV-1` and is free-running, independent of `en`/`load`/`clear`. `tick` is registered and is high on the cycle after the prescaler reaches DIV-1. The tick period is exactly DIV cycles, with no off-by-one extra cycle.
- Count update priority on each edge: `clear` > `load` > step. `clear` and `load` act on any cycle, whether or not a tick is present.
- Step occurs only on an edge where `tick`=1, `en`=1, and no clear or load is active.
  - Up: `count+1`. At MOD-1 the count goes to 0 in WRAP mode or holds in SAT mode, and `wrap`=1.
  - Down: `count-1`. At 0 the count goes to MOD-1 in WRAP mode or holds in SAT mode, and `wrap`=1.
- `wrap` is registered and high for exactly one cycle, aligned with the cycle in which the new `count` is visible. It is 0 whenever clear or load wins.
- Arithmetic uses WIDTH+1 bits internally. The compare against MOD-1 happens before the add, so the MOD = 2**WIDTH case never overflows.
- Changing `up` only affects the next step. No state depends on the previous direction.

## Timing
- Latency: `tick` high on cycle N → new `count` and `wrap` visible on cycle N+1.
- After reset release, the first `tick` is high DIV cycles after the first clock edge.
- `load`/`clear` asserted on cycle N → `count` updated on cycle N+1.
- Tick and load on the same cycle: load wins and that tick's step is lost.
- Reset mid-operation: all state clears immediately (asynchronous), regardless of the clock. Deassertion must be synchronised by the top level. The prescaler restarts from 0.

## Structure
- `tick_counter_pkg`: `ovf_mode_t` enum (`OVF_WRAP`, `OVF_SAT`), plus a `calc_div` function with elaboration-time checks.
- Sub-module `tick_gen` (params `DIV`; ports `clk`, `rst_n`, `tick`) holds the prescaler and is reused elsewhere for timebases.
- `tick_counter` instantiates `tick_gen` and the count register logic.

## Test plan
All scenarios use `CLK_FREQ=10`, `TICK_HZ=2` (DIV=5), `WIDTH=4`, `MOD=10` unless stated otherwise.
- Reset, `en`=1, `up`=1 → `tick` every 5 cycles, first on cycle 5. `count` runs 0,1,…,9,0, with `wrap`=1 for one cycle as `count` becomes 0.
- `up`=0 from reset → `count` 0→9 with `wrap` on the first step, then 8, 7, ….
- `OVF_SAT`, `load_val`=8, then up steps → 9, 9, 9 with `wrap` pulsing on each held step. Then `up`=0 → 8.
- `load`=1 with `load_val`=13 → `count`=9 next cycle. `load` on a tick cycle → no step that period, and the next tick steps from the loaded value.
- `clear` and `load` together (`load_val`=5) → `count`=0. `en`=0 across 3 ticks → `count` unchanged and `tick` still pulses.
- `rst_n` low for half a cycle mid-period → `count`, `tick` and `wrap` read 0 immediately. After release, the first tick arrives after 5 cycles.
- `MOD=16`, `WIDTH=4`, up from 15 → 0 with `wrap`=1 and no X or overflow.
